piso_tx: RTL and testbench
==========================

# piso_tx

Parallel-in serial-out transmitter that feeds the serial input of the SIPO capture block. It accepts WIDTH-bit words over a valid/ready stream, buffers them in a DEPTH-entry FIFO, and shifts each word out LSB-first on `sout`, one bit per `clk`. When the FIFO has data, words go back-to-back with no gap bits, so a downstream SIPO sampling continuously on the same `clk` reassembles the words unchanged.

## Interface
Parameters:
- WIDTH, 32: word width in bits; must be ≥2 and match the downstream SIPO width.
- DEPTH, 8: FIFO entries; must be a power of 2 and ≥2.
- IDLE_BIT, 1'b0: value driven on `sout` while no word is being shifted.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  transmit enable; sampled only at word boundaries.
- in_valid  in  1  input word valid.
- in_ready  out  1  FIFO can accept a word.
- in_data  in  WIDTH  input word.
- sout  out  1  serial data, registered.
- sout_active  out  1  high while `sout` carries a word bit, registered.
- count  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- underrun  out  1  sticky flag: the stream ran dry while enabled.
- clr_underrun  in  1  single-cycle clear for `underrun`.

## Operation
- **FIFO**
  - Read and write pointers are $clog2(DEPTH)+1 bits wide, so all DEPTH entries are usable.
  - full = pointers differ only in the MSB; empty = pointers are equal.
  - `in_ready` = !full. A push happens on in_valid && in_ready.
  - A pop frees space visible on the next cycle. There is no same-cycle pass-through when full.
  - `count` = wr_ptr − rd_ptr.
- **FSM states: IDLE, SHIFT.**
- **IDLE**
  - `sout` = IDLE_BIT, `sout_active` = 0.
  - If en && !empty: load the head word, pop it, and go to SHIFT.
  - On the load edge: sout <= word[0], sout_active <= 1, shreg <= word >> 1, bit_cnt <= 0.
- **SHIFT**, on each edge:
  - If bit_cnt < WIDTH−1: sout <= shreg[0], shift shreg right, bit_cnt++.
  - If bit_cnt == WIDTH−1 (last bit is on `sout`):
    - en && !empty: load the next word exactly as from IDLE. This gives a continuous stream with no idle bit.
    - else: go to IDLE, sout <= IDLE_BIT, sout_active <= 0.
    - en && empty: also set `underrun`.
- **en deassertion** mid-word does not truncate the word. The current word completes, then the FSM goes to IDLE without setting underrun. `en` is ignored except at IDLE and at the last-bit edge.
- **underrun**
  - Set only as described above; cleared by clr_underrun.
  - If set and clear occur on the same edge, set wins.
- **Width rules**
  - bit_cnt is $clog2(WIDTH) bits.
  - Pointer arithmetic wraps modulo 2·DEPTH. The FIFO RAM is indexed by the low $clog2(DEPTH) bits.
- **Reset** (asynchronous, any time including mid-word):
  - Pointers = 0, FSM = IDLE, bit_cnt = 0, shreg = 0.
  - Outputs: sout = IDLE_BIT, sout_active = 0, underrun = 0, count = 0, in_ready = 1.
  - A partially sent word is discarded. FIFO contents are lost.

## Timing
- **Latency:** a word accepted at edge T, with the FSM in IDLE and en = 1, is loaded at edge T+1. Bit k is on `sout` in the cycle after edge T+1+k, for k = 0..WIDTH−1.
- **Back-to-back:** word n bit WIDTH−1 is followed directly by word n+1 bit 0. `sout_active` stays high.
- **Throughput:** one word per WIDTH cycles. A push and a pop may occur on the same edge; `count` is unchanged in that case.
- **in_ready after a pop from full:** deasserted while full; reasserts in the cycle after the pop edge.
- All outputs are registered or derived only from registers (in_ready, count). There are no combinational input-to-output paths.

## Test plan
- **Single word:** WIDTH=8, en=1, push 8'hA5. Required: sout = 1,0,1,0,0,1,0,1 on the 8 cycles after edge T+1. sout_active is high for exactly 8 cycles. underrun = 1 after the last bit; sout returns to IDLE_BIT.
- **Back-to-back:** push 8'h0F then 8'hF0 with en=1. Required: 16 contiguous active cycles, bits 1111000000001111. No idle bit between words. underrun set only after bit 16.
- **Full/backpressure:** en=0, DEPTH=8, push 9 words. Required: the 9th is stalled with in_ready=0 and count=8. Raise en: the first load pops, in_ready=1 one cycle later, the 9th word is accepted, and all 9 words emerge in order.
- **en drop mid-word:** deassert en at bit 3 of a word with a second word queued. Required: the first word completes all WIDTH bits; the FSM idles with count=1 and underrun stays 0. Reassert en: the second word starts on the next edge.
- **Reset mid-word:** assert rst at bit 4 with 3 words queued. Required: immediately sout=IDLE_BIT, sout_active=0, count=0, in_ready=1, underrun=0. After release, no bits are emitted until a new push.
- **Underrun clear race:** pulse clr_underrun on the same edge that sets underrun. Required: underrun=1. A clr_underrun pulse one cycle later gives underrun=0.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: DEPTH-entry word FIFO feeding an LSB-first
// shifter that streams words back-to-back on sout while enabled and data is queued.
module piso_tx #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       sout,
  output logic                       sout_active,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       underrun,
  input  logic                       clr_underrun
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned CW   = $clog2(WIDTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  head;
  logic [WIDTH-1:0]  shreg;
  logic [CW-1:0]     bit_cnt;
  logic              full, empty, push, pop;
  logic              load, shift, stop, set_underrun;

  // FIFO: extra pointer MSB distinguishes full from empty so all entries are usable.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = load;
  assign count    = CNTW'(wr_ptr - rd_ptr);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // en only matters in IDLE and on the last-bit edge, so a word is never truncated.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    shift        = 1'b0;
    stop         = 1'b0;
    set_underrun = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != LAST) begin
          shift = 1'b1;
        end else if (en && !empty) begin
          load = 1'b1;
        end else begin
          stop         = 1'b1;
          set_underrun = en;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      sout        <= IDLE_BIT;
      sout_active <= 1'b0;
    end else if (load) begin
      sout        <= head[0];
      sout_active <= 1'b1;
      shreg       <= head >> 1;
      bit_cnt     <= '0;
    end else if (shift) begin
      sout    <= shreg[0];
      shreg   <= shreg >> 1;
      bit_cnt <= bit_cnt + 1'b1;
    end else if (stop) begin
      sout        <= IDLE_BIT;
      sout_active <= 1'b0;
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               underrun <= 1'b0;
    else if (set_underrun) underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx (WIDTH=8, DEPTH=8): vector table plus hand sequences.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       rst, en, in_valid, in_ready, sout, sout_active, underrun, clr_underrun;
  logic [7:0] in_data;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(8), .DEPTH(8), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sout(sout), .sout_active(sout_active), .count(count),
    .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       en;
    logic       clr;
    logic       sout;
    logic       act;
    logic       und;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic vld, input logic [7:0] data, input logic e, input logic clr,
                     input logic so, input logic act, input logic und, input logic [3:0] cnt);
    vec_t v;
    v.vld = vld; v.data = data; v.en = e; v.clr = clr;
    v.sout = so; v.act = act; v.und = und; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    logic       bits [72];
    int         nb;
    int         act_cycles;

    // Single word A5, then clear the underrun it leaves behind.
    w = 8'hA5;
    add(1, 8'hA5, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 8'h00, 1, 0, w[k], 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    // Back-to-back 0F then F0: no gap bit, underrun only after bit 16.
    w = 8'h0F; w2 = 8'hF0;
    add(1, 8'h0F, 1, 0, 0, 0, 0, 1);
    add(1, 8'hF0, 1, 0, w[0], 1, 0, 1);
    for (int k = 1; k < 8; k++) add(0, 8'h00, 1, 0, w[k], 1, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 8'h00, 1, 0, w2[k], 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0, 1, 0);
    // Clear/set race: set wins, a later clear works.
    w = 8'h01;
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);
    add(1, 8'h01, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 8; k++) add(0, 8'h00, 1, 0, w[k], 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1, 0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 0);

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; clr_underrun = 1'b0;
    step();
    step();
    chk("reset_sout", sout, 0);
    chk("reset_active", sout_active, 0);
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_underrun", underrun, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].vld; in_data = tbl[i].data;
      en = tbl[i].en; clr_underrun = tbl[i].clr;
      step();
      chk($sformatf("vec%0d_sout", i), sout, tbl[i].sout);
      chk($sformatf("vec%0d_active", i), sout_active, tbl[i].act);
      chk($sformatf("vec%0d_underrun", i), underrun, tbl[i].und);
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
    end
    in_valid = 1'b0; clr_underrun = 1'b0;

    // Full/backpressure: 9 words with en low, 9th stalls until the first pop.
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      step();
    end
    in_data = 8'h18;
    step();
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    en = 1'b1;
    step();
    chk("pop_count", count, 7);
    chk("pop_in_ready", in_ready, 1);
    nb = 0;
    if (sout_active) begin bits[nb] = sout; nb++; end
    step();
    in_valid = 1'b0;
    chk("ninth_push_count", count, 8);
    if (sout_active) begin bits[nb] = sout; nb++; end
    for (int c = 0; c < 200 && nb < 72; c++) begin
      step();
      if (sout_active) begin bits[nb] = sout; nb++; end
    end
    chk("full_bits_collected", nb, 72);
    for (int j = 0; j < 9; j++) begin
      for (int b = 0; b < 8; b++) w[b] = (nb == 72) ? bits[j*8+b] : 1'bx;
      chk($sformatf("full_word%0d", j), w, 8'h10 + 8'(j));
    end
    step();
    chk("full_end_active", sout_active, 0);
    chk("full_end_underrun", underrun, 1);
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;

    // en drop at bit 3: word completes, second word waits, no underrun.
    en = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; step();
    in_data = 8'hC3; step();
    in_valid = 1'b0;
    chk("endrop_count_init", count, 2);
    en = 1'b1;
    step();
    chk("endrop_load_sout", sout, 0);
    chk("endrop_load_count", count, 1);
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    chk("endrop_bit3", sout, 1);
    for (int i = 0; i < 4; i++) step();
    chk("endrop_bit7_active", sout_active, 1);
    chk("endrop_bit7", sout, 0);
    step();
    chk("endrop_idle_active", sout_active, 0);
    chk("endrop_idle_count", count, 1);
    chk("endrop_underrun", underrun, 0);
    step();
    step();
    chk("endrop_still_idle", sout_active, 0);
    en = 1'b1;
    step();
    chk("endrop_resume_active", sout_active, 1);
    chk("endrop_resume_sout", sout, 1);
    chk("endrop_resume_count", count, 0);
    en = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("endrop_final_active", sout_active, 0);
    chk("endrop_final_underrun", underrun, 0);

    // Reset mid-word with 3 words still queued.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'h55 + 8'(i * 17);
      step();
    end
    in_valid = 1'b0;
    en = 1'b1;
    step();
    chk("rstmid_count", count, 3);
    for (int i = 0; i < 4; i++) step();
    chk("rstmid_active_before", sout_active, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_sout", sout, 0);
    chk("rstmid_active", sout_active, 0);
    chk("rstmid_count0", count, 0);
    chk("rstmid_in_ready", in_ready, 1);
    chk("rstmid_underrun", underrun, 0);
    step();
    rst = 1'b0;
    act_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sout_active) act_cycles++;
    end
    chk("rstmid_no_bits", act_cycles, 0);
    chk("rstmid_count_after", count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
